// File: rtl/mnist_result_evaluator.sv
// mnist_result_evaluator
//   Scores a binary-output classifier. Each sample carries CHANNEL_NUM sets of
//   CLASS_NUM one-bit votes. The votes per class are summed, the class with the
//   strictly largest sum wins (lowest index on ties, CLASS_NUM when nobody
//   votes), and the winner is compared with the expected label. Per-batch
//   sample and hit counts are presented when the last sample of a batch leaves
//   the pipeline.
//
// Ports
//   clk, reset      : rising-edge clock, asynchronous active-high reset
//   cke             : clock enable, 0 freezes every register
//   in_user         : expected class label
//   in_last         : final sample of a batch
//   in_data         : votes, bit j*CLASS_NUM+i = channel j votes for class i
//   in_valid        : sample qualifier (no backpressure)
//   out_class       : winning class, CLASS_NUM when there is no vote
//   out_user        : label aligned with out_class
//   out_match       : out_class equals out_user
//   out_last        : aligned in_last, qualified by valid
//   out_valid       : result qualifier, two enabled cycles after in_valid
//   stat_data_count : samples in the batch so far, including the current one
//   stat_ok_count   : matches in the batch so far, including the current one
//   stat_valid      : one-cycle pulse carrying the batch totals
module mnist_result_evaluator #(
    parameter int USER_WIDTH  = 8,
    parameter int CLASS_NUM   = 10,
    parameter int CHANNEL_NUM = 1,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                             reset,
    input  logic                             clk,
    input  logic                             cke,
    input  logic [USER_WIDTH-1:0]            in_user,
    input  logic                             in_last,
    input  logic [CLASS_NUM*CHANNEL_NUM-1:0] in_data,
    input  logic                             in_valid,
    output logic [$clog2(CLASS_NUM+1)-1:0]   out_class,
    output logic [USER_WIDTH-1:0]            out_user,
    output logic                             out_match,
    output logic                             out_last,
    output logic                             out_valid,
    output logic [COUNT_WIDTH-1:0]           stat_data_count,
    output logic [COUNT_WIDTH-1:0]           stat_ok_count,
    output logic                             stat_valid
);

    localparam int SUM_W = $clog2(CHANNEL_NUM + 1);
    localparam int CLS_W = $clog2(CLASS_NUM + 1);
    localparam int CMP_W = (CLS_W > USER_WIDTH) ? CLS_W : USER_WIDTH;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] cnt,
                                                       input logic                   inc);
        if (inc && (cnt != '1)) begin
            return cnt + COUNT_WIDTH'(1);
        end
        return cnt;
    endfunction

    logic [SUM_W-1:0]       sum_d [CLASS_NUM];
    logic [SUM_W-1:0]       sum_p1_q [CLASS_NUM];
    logic [USER_WIDTH-1:0]  user_p1_q;
    logic                   last_p1_q;
    logic                   vld_p1_q;

    logic [SUM_W-1:0]       best_sum;
    logic [CLS_W-1:0]       class_d;
    logic                   match_d;

    logic [CLS_W-1:0]       out_class_q;
    logic [USER_WIDTH-1:0]  out_user_q;
    logic                   out_match_q;
    logic                   out_last_q;
    logic                   out_valid_q;

    logic [COUNT_WIDTH-1:0] data_cnt_q;
    logic [COUNT_WIDTH-1:0] ok_cnt_q;
    logic [COUNT_WIDTH-1:0] data_cnt_d;
    logic [COUNT_WIDTH-1:0] ok_cnt_d;

    // ---- stage 0 -> 1: per-class vote count over all channels ----
    always_comb begin
        for (int i = 0; i < CLASS_NUM; i++) begin
            sum_d[i] = '0;
            for (int j = 0; j < CHANNEL_NUM; j++) begin
                sum_d[i] = sum_d[i] + SUM_W'(in_data[j*CLASS_NUM+i]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1_q  <= 1'b0;
            last_p1_q <= 1'b0;
        end else if (cke) begin
            vld_p1_q  <= in_valid;
            last_p1_q <= in_last & in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (cke && in_valid) begin
            sum_p1_q  <= sum_d;
            user_p1_q <= in_user;
        end
    end

    // ---- stage 1 -> 2: argmax and label comparison ----
    // Strict '>' keeps the lowest index on ties; a zero start value means an
    // all-zero vote vector leaves the CLASS_NUM "no vote" code in place.
    always_comb begin
        best_sum = '0;
        class_d  = CLS_W'(CLASS_NUM);
        for (int i = 0; i < CLASS_NUM; i++) begin
            if (sum_p1_q[i] > best_sum) begin
                best_sum = sum_p1_q[i];
                class_d  = CLS_W'(i);
            end
        end
        match_d = (class_d != CLS_W'(CLASS_NUM)) &&
                  (CMP_W'(class_d) == CMP_W'(user_p1_q));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_match_q <= 1'b0;
            out_class_q <= CLS_W'(CLASS_NUM);
            out_user_q  <= '0;
        end else if (cke) begin
            out_valid_q <= vld_p1_q;
            out_last_q  <= last_p1_q;
            if (vld_p1_q) begin
                out_class_q <= class_d;
                out_user_q  <= user_p1_q;
                out_match_q <= match_d;
            end
        end
    end

    // ---- stage 2: batch statistics ----
    // The presented totals already include the sample currently on the output,
    // so the last sample of a batch is reported in the same cycle it appears.
    assign data_cnt_d = sat_inc(data_cnt_q, out_valid_q);
    assign ok_cnt_d   = sat_inc(ok_cnt_q, out_valid_q & out_match_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_cnt_q <= '0;
            ok_cnt_q   <= '0;
        end else if (cke) begin
            if (out_valid_q && out_last_q) begin
                data_cnt_q <= '0;
                ok_cnt_q   <= '0;
            end else if (out_valid_q) begin
                data_cnt_q <= data_cnt_d;
                ok_cnt_q   <= ok_cnt_d;
            end
        end
    end

    assign out_class       = out_class_q;
    assign out_user        = out_user_q;
    assign out_match       = out_match_q;
    assign out_last        = out_last_q;
    assign out_valid       = out_valid_q;
    assign stat_data_count = data_cnt_d;
    assign stat_ok_count   = ok_cnt_d;
    // Gated by cke so a frozen cycle can never report the same batch twice.
    assign stat_valid      = cke & out_valid_q & out_last_q;

endmodule

// File: tb/tb_mnist_result_evaluator.sv
// Directed bench for mnist_result_evaluator: a 3-channel instance carries
// the main scenarios, a 1-channel instance with 2-bit counters shares the
// same stimulus (channel 0 bits) to cover single-channel voting and counter
// saturation.
module tb_mnist_result_evaluator;

    logic        clk = 1'b0;
    logic        reset;
    logic        cke;
    logic [7:0]  in_user;
    logic        in_last;
    logic        in_valid;
    logic [29:0] in_data;
    logic [9:0]  in_data1;

    logic [3:0]  o3_class;
    logic [7:0]  o3_user;
    logic        o3_match, o3_last, o3_valid, o3_sv;
    logic [31:0] o3_dc, o3_ok;

    logic [3:0]  o1_class;
    logic [7:0]  o1_user;
    logic        o1_match, o1_last, o1_valid, o1_sv;
    logic [1:0]  o1_dc, o1_ok;

    assign in_data1 = in_data[9:0];

    mnist_result_evaluator #(.USER_WIDTH(8), .CLASS_NUM(10), .CHANNEL_NUM(3), .COUNT_WIDTH(32)) dut3 (
        .reset(reset), .clk(clk), .cke(cke), .in_user(in_user), .in_last(in_last),
        .in_data(in_data), .in_valid(in_valid), .out_class(o3_class), .out_user(o3_user),
        .out_match(o3_match), .out_last(o3_last), .out_valid(o3_valid),
        .stat_data_count(o3_dc), .stat_ok_count(o3_ok), .stat_valid(o3_sv));

    mnist_result_evaluator #(.USER_WIDTH(8), .CLASS_NUM(10), .CHANNEL_NUM(1), .COUNT_WIDTH(2)) dut1 (
        .reset(reset), .clk(clk), .cke(cke), .in_user(in_user), .in_last(in_last),
        .in_data(in_data1), .in_valid(in_valid), .out_class(o1_class), .out_user(o1_user),
        .out_match(o1_match), .out_last(o1_last), .out_valid(o1_valid),
        .stat_data_count(o1_dc), .stat_ok_count(o1_ok), .stat_valid(o1_sv));

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // Batch-total pulses seen on the 3-channel instance, sampled mid-cycle.
    int          pulses = 0;
    logic [31:0] p_dc   = '0;
    logic [31:0] p_ok   = '0;

    always @(negedge clk) begin
        if (o3_sv) begin
            pulses = pulses + 1;
            p_dc   = o3_dc;
            p_ok   = o3_ok;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [29:0] vote(input int bitpos);
        logic [29:0] v;
        v = 30'd1;
        return v << bitpos;
    endfunction

    task automatic send(input logic v, input logic l, input logic [7:0] u, input logic [29:0] d);
        in_valid = v;
        in_last  = l;
        in_user  = u;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    // Holds the sample until a cycle with cke=1 has taken it.
    task automatic send_rc(input logic v, input logic l, input logic [7:0] u, input logic [29:0] d);
        in_valid = v;
        in_last  = l;
        in_user  = u;
        in_data  = d;
        for (int k = 0; k < 8; k++) begin
            cke = (k == 7) ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (cke) break;
        end
    endtask

    int          bcls [7] = '{1, 2, 3, 4, 5, 6, 7};
    int          blbl [7] = '{1, 9, 3, 9, 5, 6, 7};
    int          e3dc [7] = '{1, 2, 3, 4, 5, 1, 2};
    int          e1dc [7] = '{1, 2, 3, 3, 3, 1, 2};
    int          eok  [7] = '{1, 1, 2, 2, 3, 1, 2};
    int          esv  [7] = '{0, 0, 0, 0, 1, 0, 1};
    logic [5:0]  okpat;
    int          p0;

    initial begin
        reset = 1'b1; cke = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; in_user = '0; in_data = '0;
        #1;
        chk("rst_valid", 32'(o3_valid), 0);
        chk("rst_class", 32'(o3_class), 10);
        chk("rst_user",  32'(o3_user), 0);
        chk("rst_sv",    32'(o3_sv), 0);
        chk("rst_dc",    o3_dc, 0);
        chk("rst_class1", 32'(o1_class), 10);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // single vote for class 3, label 3
        send(1'b1, 1'b1, 8'd3, vote(3));
        send(1'b0, 1'b0, 8'd0, '0);
        chk("t1_valid1", 32'(o1_valid), 1);
        chk("t1_class1", 32'(o1_class), 3);
        chk("t1_match1", 32'(o1_match), 1);
        chk("t1_user1",  32'(o1_user), 3);
        chk("t1_class3", 32'(o3_class), 3);
        chk("t1_sv",     32'(o3_sv), 1);
        chk("t1_dc",     o3_dc, 1);
        chk("t1_ok",     o3_ok, 1);
        cke = 1'b0; #1;
        chk("cke0_sv", 32'(o3_sv), 0);
        chk("cke0_dc", o3_dc, 1);
        @(posedge clk); #1;
        chk("cke0_hold", 32'(o3_valid), 1);
        cke = 1'b1; #1;
        chk("cke1_sv", 32'(o3_sv), 1);
        @(posedge clk); #1;
        chk("t1_drain_valid", 32'(o3_valid), 0);
        chk("t1_drain_dc", o3_dc, 0);

        // channel votes 2/2/5, label 5
        send(1'b1, 1'b1, 8'd5, vote(2) | vote(12) | vote(25));
        // tie between class 4 and class 7, label 4
        send(1'b1, 1'b1, 8'd4, vote(4) | vote(7) | vote(14) | vote(17));
        chk("t2_class", 32'(o3_class), 2);
        chk("t2_match", 32'(o3_match), 0);
        chk("t2_ok",    o3_ok, 0);
        // no votes, label 0
        send(1'b1, 1'b1, 8'd0, '0);
        chk("t3_class", 32'(o3_class), 4);
        chk("t3_match", 32'(o3_match), 1);
        chk("t3_ok",    o3_ok, 1);
        // no votes, label equal to the no-vote code
        send(1'b1, 1'b1, 8'd10, '0);
        chk("t4_class", 32'(o3_class), 10);
        chk("t4_match", 32'(o3_match), 0);
        send(1'b0, 1'b0, 8'd0, '0);
        chk("t5_class", 32'(o3_class), 10);
        chk("t5_user",  32'(o3_user), 10);
        chk("t5_match", 32'(o3_match), 0);
        send(1'b0, 1'b0, 8'd0, '0);

        // 5-sample batch (3 correct) followed directly by a 2-sample batch
        p0 = pulses;
        for (int s = 0; s < 8; s++) begin
            if (s < 7) send(1'b1, (s == 4) || (s == 6), 8'(blbl[s]), vote(bcls[s]));
            else       send(1'b0, 1'b0, 8'd0, '0);
            if (s >= 1) begin
                chk($sformatf("b_class[%0d]", s - 1), 32'(o3_class), 32'(bcls[s-1]));
                chk($sformatf("b_sv[%0d]", s - 1),    32'(o3_sv), 32'(esv[s-1]));
                chk($sformatf("b_dc[%0d]", s - 1),    o3_dc, 32'(e3dc[s-1]));
                chk($sformatf("b_ok[%0d]", s - 1),    o3_ok, 32'(eok[s-1]));
                chk($sformatf("b_dc1[%0d]", s - 1),   32'(o1_dc), 32'(e1dc[s-1]));
                chk($sformatf("b_ok1[%0d]", s - 1),   32'(o1_ok), 32'(eok[s-1]));
            end
        end
        send(1'b0, 1'b0, 8'd0, '0);
        chk("b_pulses", 32'(pulses - p0), 2);
        chk("b_last_dc", p_dc, 2);
        chk("b_last_ok", p_ok, 2);

        // 6-sample batch with random clock enable, 4 correct
        okpat = 6'b101101;
        p0 = pulses;
        for (int i = 0; i < 6; i++)
            send_rc(1'b1, i == 5, okpat[i] ? 8'(i) : 8'(i + 1), vote(i));
        repeat (3) send_rc(1'b0, 1'b0, 8'd0, '0);
        chk("rc_pulses", 32'(pulses - p0), 1);
        chk("rc_dc", p_dc, 6);
        chk("rc_ok", p_ok, 4);

        // reset asserted mid-batch, between clock edges
        cke = 1'b1;
        p0 = pulses;
        for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 8'(i), vote(i));
        chk("pre_rst_valid", 32'(o3_valid), 1);
        #3 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(o3_valid), 0);
        chk("arst_class", 32'(o3_class), 10);
        chk("arst_user",  32'(o3_user), 0);
        chk("arst_match", 32'(o3_match), 0);
        chk("arst_dc",    o3_dc, 0);
        chk("arst_ok",    o3_ok, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        send_rc(1'b1, 1'b0, 8'd4, vote(4));
        send_rc(1'b1, 1'b1, 8'd1, vote(6));
        repeat (3) send_rc(1'b0, 1'b0, 8'd0, '0);
        chk("post_rst_pulses", 32'(pulses - p0), 1);
        chk("post_rst_dc", p_dc, 2);
        chk("post_rst_ok", p_ok, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mnist_result_evaluator.md
MNIST_RESULT_EVALUATOR -- requirements
Module: mnist_result_evaluator

Interface
REQ-001 Parameter USER_WIDTH, default 8, width of the label carried with each sample.
REQ-002 Parameter CLASS_NUM, default 10, number of classes.
REQ-003 Parameter CHANNEL_NUM, default 1, spatial channel multiplicity; in_data bit j*CLASS_NUM+i is channel j's vote for class i.
REQ-004 Parameter COUNT_WIDTH, default 32, width of the statistics counters.
REQ-005 Port reset, input, 1, asynchronous, active-high.
REQ-006 Port clk, input, 1; all state changes on its rising edge.
REQ-007 Port cke, input, 1, clock enable; 0 freezes all registers.
REQ-008 Port in_user, input, USER_WIDTH, expected class label.
REQ-009 Port in_last, input, 1, marks the final sample of a batch.
REQ-010 Port in_data, input, CLASS_NUM*CHANNEL_NUM, binary network output.
REQ-011 Port in_valid, input, 1, sample qualifier; there is no backpressure.
REQ-012 Port out_class, output, $clog2(CLASS_NUM+1), winning class index, or CLASS_NUM when there is no vote.
REQ-013 Port out_user, output, USER_WIDTH, label delayed to align with out_class.
REQ-014 Port out_match, output, 1, high when out_class equals out_user.
REQ-015 Port out_last, output, 1, delayed in_last.
REQ-016 Port out_valid, output, 1, result qualifier.
REQ-017 Port stat_data_count, output, COUNT_WIDTH, number of samples in the batch.
REQ-018 Port stat_ok_count, output, COUNT_WIDTH, number of matches in the batch.
REQ-019 Port stat_valid, output, 1, one-cycle pulse presenting batch totals.

Function
REQ-020 Stage 1 (cke=1) SHALL register per-class sums, user, last and valid.
- Per-class sum = count of set bits over the CHANNEL_NUM votes for that class.
- Sum width = $clog2(CHANNEL_NUM+1), no overflow possible.
REQ-021 Stage 2 (cke=1) SHALL register argmax, match, user, last and valid.
- Argmax winner has strictly the largest sum; ties go to the lowest index.
- All sums zero gives out_class = CLASS_NUM.
REQ-022 out_match SHALL be high only if out_class equals out_user zero-extended; a no-vote result never matches.
REQ-023 Latency SHALL be exactly 2 enabled cycles from in_valid sampled to out_valid; throughput is one sample per cycle.
REQ-024 Stage 1 and stage 2 data registers SHALL only load when the stage input valid is high; valid and last bits load every enabled cycle.
REQ-025 Internal counters data_cnt and ok_cnt SHALL update in the cycle out_valid is high.
- data_cnt += 1.
- ok_cnt += out_match.
- Both saturate at 2^COUNT_WIDTH-1.
REQ-026 When out_valid and out_last are both high, stat_valid SHALL pulse in that same cycle.
- stat_* values are combinational: counter value plus the current sample.
- Counters clear to 0 at the next enabled edge, ready for the next batch.
REQ-027 stat_data_count and stat_ok_count SHALL show running totals including the current valid sample when stat_valid is low.
REQ-028 A sample with in_last and in_valid low SHALL have no effect; out_last is qualified by out_valid.
REQ-029 With cke=0, all registers SHALL hold and stat_valid SHALL be forced 0; no sample is counted twice.
REQ-030 Back-to-back batches SHALL be supported: a new batch's first sample may immediately follow the last sample without a gap.

Reset
REQ-031 On reset assertion, without waiting for clk, the following SHALL clear to 0: out_valid, out_last, out_match, stat_valid, both counters, and all stage valid bits.
- out_class resets to CLASS_NUM; out_user resets to 0.
REQ-032 Reset mid-batch SHALL discard in-flight samples and partial counts; the first sample after release starts a new batch.

Verification
REQ-033 CHANNEL_NUM=1, in_data=10'b0000001000, label 3 -> 2 cycles later out_class=3, out_match=1, out_valid=1.
REQ-034 CHANNEL_NUM=3, channel votes class 2/2/5, label 5 -> out_class=2, out_match=0.
REQ-035 Tie between class 4 and class 7 (sums 2/2) -> out_class=4.
REQ-036 in_data all zero, label 0 -> out_class=10, out_match=0.
REQ-037 Batch of 5 consecutive samples with 3 correct, last flagged on the 5th.
- stat_valid pulses once with stat_data_count=5, stat_ok_count=3.
- An immediately following 2-sample batch, both correct, reports 2/2.
REQ-038 cke toggled 0/1 randomly during a batch, plus reset asserted asynchronously mid-batch.
- Totals match a reference model and no duplicates occur.
- Outputs go to their reset values immediately; the post-release batch counts from 0.
